// File: rtl/rx_leds.sv
// 8N1 UART receiver (LSB first) that shows the low nibble of each received byte on four LEDs.
// Optional stop-bit framing check: define RXLEDS_FRAMING_CHECK_EN.
module rx_leds #(
    parameter int BAUDRATE = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [3:0] leds
);

    localparam int CW = $clog2(BAUDRATE) + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUDRATE / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUDRATE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t          state_q, state_d;
    logic            rx_s1_q, rx_s2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic [1:0]      prime_q, prime_d;
    logic            armed_q, armed_d;
    logic            expire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            prime_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            prime_q   <= prime_d;
            armed_q   <= armed_d;
        end
    end

    // A load of N expires on the Nth following tick, as the count reaches zero.
    assign expire = (cnt_q <= CW'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        armed_d   = armed_q;
        // The synchronizer holds reset values for two cycles; only trust it after that.
        prime_d   = {prime_q[0], 1'b1};

        case (state_q)
            IDLE: begin
                if (!armed_q) begin
                    if (prime_q[1] && rx_s2_q) begin
                        armed_d = 1'b1;
                    end
                end else if (!rx_s2_q) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_s2_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = FULL_BIT;
                        bit_cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    cnt_d     = FULL_BIT;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (expire) begin
                    cnt_d = '0;
`ifdef RXLEDS_FRAMING_CHECK_EN
                    // Broken frame: drop it and stay idle-disarmed until the line is high again.
                    if (!rx_s2_q) begin
                        state_d = IDLE;
                        armed_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LOAD: begin
                data_d  = shift_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign leds = data_q[3:0];

endmodule

// File: tb/tb_rx_leds.sv
// Directed bench for rx_leds: reset, idle, frame latency, false start, mid-frame reset, stop-bit handling.
module tb_rx_leds;

    localparam int B       = 104;
    localparam int LATENCY = 2 + B / 2 + 9 * B + 2;

    logic       clk;
    logic       rstn;
    logic       rx;
    logic [3:0] leds;

    int checks;
    int errors;

    rx_leds #(.BAUDRATE(B)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .leds (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one frame starting immediately; caller is aligned to a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop_bit;
        repeat (B) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * B) @(negedge clk);
    endtask

    // Sends a frame and checks leds hold the old value up to the last cycle and change exactly at LATENCY.
    task automatic frame_timed(input string name, input logic [7:0] b, input logic stop_bit,
                               input logic [3:0] old_val, input logic [3:0] new_val);
        @(negedge clk);
        fork
            send_frame(b, stop_bit);
            begin
                repeat (LATENCY - 1) @(posedge clk);
                @(negedge clk);
                checks++;
                if (leds !== old_val) begin
                    errors++;
                    $display("FAIL %s_before leds=%b expected=%b", name, leds, old_val);
                end
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (leds !== new_val) begin
                    errors++;
                    $display("FAIL %s_after leds=%b expected=%b", name, leds, new_val);
                end
            end
        join
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL reset_leds leds=%b expected=0000", leds);
        end
        rstn = 1'b1;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            repeat (B) @(negedge clk);
            checks++;
            if (leds !== 4'b0000) begin
                errors++;
                $display("FAIL idle_%0d leds=%b expected=0000", i, leds);
            end
        end
    endtask

    task automatic test_frames;
        frame_timed("frame_55", 8'h55, 1'b1, 4'b0000, 4'b0101);
        idle_bits(4);
        frame_timed("frame_4B", 8'h4B, 1'b1, 4'b0101, 4'b1011);
        idle_bits(2);
    endtask

    task automatic test_false_start;
        rx = 1'b0;
        repeat (B / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        checks++;
        if (leds !== 4'b1011) begin
            errors++;
            $display("FAIL false_start leds=%b expected=1011", leds);
        end
        frame_timed("frame_0F", 8'h0F, 1'b1, 4'b1011, 4'b1111);
        idle_bits(2);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        b = 8'hA3;
        @(negedge clk);
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = b[3];
        repeat (B / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL midframe_reset_async leds=%b expected=0000", leds);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (B / 2) @(negedge clk);
        rx = b[4];
        repeat (B) @(negedge clk);
        idle_bits(12);
        checks++;
        if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL after_reset_idle leds=%b expected=0000", leds);
        end
        frame_timed("frame_3C", 8'h3C, 1'b1, 4'b0000, 4'b1100);
        idle_bits(2);
    endtask

    task automatic test_stop_bit;
        logic [3:0] exp_val;
`ifdef RXLEDS_FRAMING_CHECK_EN
        exp_val = 4'b1100;
`else
        exp_val = 4'b1001;
`endif
        frame_timed("frame_09_badstop", 8'h09, 1'b0, 4'b1100, exp_val);
        idle_bits(3);
        checks++;
        if (leds !== exp_val) begin
            errors++;
            $display("FAIL badstop_settled leds=%b expected=%b", leds, exp_val);
        end
        frame_timed("frame_after_badstop", 8'h0A, 1'b1, exp_val, 4'b1010);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        rx     = 1'b1;
        test_reset;
        test_idle;
        test_frames;
        test_false_start;
        test_reset_midframe;
        test_stop_bit;
        idle_bits(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
